// File: rtl/lcd_mmio_ctrl_pkg.sv
// lcd_mmio_ctrl_pkg: register map, status bits, FSM states and HD44780 opcodes for the LCD responder.
package lcd_mmio_ctrl_pkg;
    localparam logic [1:0] LCD_DATA   = 2'd0;
    localparam logic [1:0] LCD_CTRL   = 2'd1;
    localparam logic [1:0] LCD_STATUS = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} lcd_state_e;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    // A zero-length phase would never reach the exit count, so clamp it to one cycle.
    function automatic logic [31:0] nz(input int unsigned v);
        return (v == 0) ? 32'd1 : 32'(v);
    endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous command FIFO with flush; a push on a full FIFO is accepted only alongside a pop.
module lcd_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign o_rdata = mem[rd_ptr];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk)
        if (do_push && !i_flush) mem[wr_ptr] <= i_wdata;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            wr_ptr  <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr  <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            o_count <= o_count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/lcd_mmio_ctrl.sv
// lcd_mmio_ctrl: memory-mapped HD44780 responder; queued bytes are played out with setup/pulse/hold/exec timing.
module lcd_mmio_ctrl
    import lcd_mmio_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_5000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_HIGH_CYC    = 12,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned EXEC_CYC       = 2000,
    parameter int unsigned CLEAR_EXEC_CYC = 80000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_lcd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    lcd_state_e    state, state_d;
    logic [31:0]   cnt, cnt_d, cnt32;
    logic          on, ovf, rs_q, long_wait;
    logic [7:0]    data_q;
    logic          hit, wr, push_req, ctrl_wr, flush, pop;
    logic [1:0]    off;
    logic          full, empty;
    logic [8:0]    head;
    logic [CW-1:0] count;
    logic [3:0]    cnt_disp;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{i_st_data[31:9], i_lsu_addr[1:0]};
    assign hit       = (i_lsu_addr[31:4] == BASE_ADDR[31:4]);
    assign off       = i_lsu_addr[3:2];
    assign wr        = i_lsu_wren && hit;
    assign push_req  = wr && (off == LCD_DATA);
    assign ctrl_wr   = wr && (off == LCD_CTRL);
    assign flush     = ctrl_wr && i_st_data[1];
    assign pop       = (state == IDLE) && on && !empty;
    assign long_wait = !rs_q && (data_q == OP_CLEAR || data_q == OP_HOME || data_q == OP_HOME_ALT);

    lcd_cmd_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push_req),
        .i_wdata (i_st_data[8:0]),
        .i_pop   (pop),
        .i_flush (flush),
        .o_rdata (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            on     <= 1'b0;
            ovf    <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            on    <= ctrl_wr ? i_st_data[0] : on;
            ovf   <= (ctrl_wr && i_st_data[2]) ? 1'b0 : (ovf || (push_req && full && !pop));
            if (pop) {rs_q, data_q} <= head;
        end
    end

    // Each phase reloads the down-counter on entry and exits when it reaches 1.
    always_comb begin
        state_d = state;
        cnt_d   = cnt - 32'd1;
        case (state)
            IDLE:  begin
                cnt_d = cnt;
                if (pop) begin state_d = SETUP; cnt_d = nz(SETUP_CYC); end
            end
            SETUP: if (cnt == 32'd1) begin state_d = PULSE; cnt_d = nz(EN_HIGH_CYC); end
            PULSE: if (cnt == 32'd1) begin state_d = HOLD;  cnt_d = nz(HOLD_CYC); end
            HOLD:  if (cnt == 32'd1) begin
                state_d = WAIT;
                cnt_d   = long_wait ? nz(CLEAR_EXEC_CYC) : nz(EXEC_CYC);
            end
            WAIT:  if (cnt == 32'd1) begin state_d = IDLE; cnt_d = '0; end
            default: begin state_d = IDLE; cnt_d = '0; end
        endcase
    end

    assign cnt32    = 32'(count);
    assign cnt_disp = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];

    always_comb begin
        status                          = '0;
        status[ST_BUSY]                 = (state != IDLE);
        status[ST_FULL]                 = full;
        status[ST_EMPTY]                = empty;
        status[ST_OVF]                  = ovf;
        status[ST_CNT_LSB+3:ST_CNT_LSB] = cnt_disp;
    end

    assign o_ld_data = !(hit && i_func3 == 3'b010) ? 32'd0 :
                       (off == LCD_CTRL)   ? {31'd0, on} :
                       (off == LCD_STATUS) ? status : 32'd0;
    assign o_io_lcd  = {on, 20'd0, (state == PULSE), rs_q, 1'b0, data_q};
endmodule
